// File: rtl/syscall_print_ctrl.sv
// Instruction-memory read-port arbiter: passes fetches through and, on a print syscall,
// walks a null-terminated string and streams its bytes. Optional trailing newline: PRINT_NEWLINE_EN.
module syscall_print_ctrl #(
  parameter int MAX_WORDS = 1024,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_stall,
  output logic              fetch_valid,
  output logic [31:0]       fetch_instr,
  input  logic              print_req,
  input  logic [ADDR_W-1:0] print_index,
  output logic              print_busy,
  output logic              print_done,
  output logic              print_overrun,
  output logic [ADDR_W-3:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              char_valid,
  output logic [7:0]        char_data,
  input  logic              char_ready
);

  localparam int CNT_W = $clog2(MAX_WORDS + 1);
  localparam int WA_W  = ADDR_W - 2;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [WA_W-1:0]  PTR_ONE = WA_W'(1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WAIT = 3'd2,
    EMIT = 3'd3,
    NL   = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t           state_r;
  logic [WA_W-1:0]  ptr_r;
  logic [1:0]       start_lane_r;
  logic [1:0]       lane_r;
  logic             first_r;
  logic [CNT_W-1:0] wcnt_r;
  logic [31:0]      word_r;
  logic             overrun_r;
  logic             fetch_valid_r;
  logic             fetch_zero_r;
  logic [7:0]       cur_byte_s;
  logic             grant_s;

  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] l);
    case (l)
      2'd0:    lane_byte = w[7:0];
      2'd1:    lane_byte = w[15:8];
      2'd2:    lane_byte = w[23:16];
      default: lane_byte = w[31:24];
    endcase
  endfunction

  assign cur_byte_s = lane_byte(word_r, lane_r);
  assign grant_s    = (state_r == IDLE) && fetch_req && !print_req;

  // Sequencer state, string walker registers and fetch-return tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      ptr_r         <= {WA_W{1'b0}};
      start_lane_r  <= 2'd0;
      lane_r        <= 2'd0;
      first_r       <= 1'b0;
      wcnt_r        <= {CNT_W{1'b0}};
      word_r        <= 32'h0000_0000;
      overrun_r     <= 1'b0;
      fetch_valid_r <= 1'b0;
      fetch_zero_r  <= 1'b0;
    end else begin
      fetch_valid_r <= grant_s;
      fetch_zero_r  <= (fetch_addr == {ADDR_W{1'b0}});
      case (state_r)
        IDLE: begin
          if (print_req) begin
            ptr_r        <= print_index[ADDR_W-1:2];
            start_lane_r <= print_index[1:0];
            first_r      <= 1'b1;
            wcnt_r       <= {CNT_W{1'b0}};
            overrun_r    <= 1'b0;
            state_r      <= RD;
          end else begin
            state_r <= IDLE;
          end
        end
        RD: begin
          wcnt_r  <= wcnt_r + CNT_ONE;
          state_r <= WAIT;
        end
        WAIT: begin
          word_r  <= mem_rdata;
          lane_r  <= first_r ? start_lane_r : 2'd0;
          first_r <= 1'b0;
          state_r <= EMIT;
        end
        EMIT: begin
          if (cur_byte_s == 8'h00) begin
            state_r <= NL;
          end else if (char_ready) begin
            if (lane_r == 2'd3) begin
              ptr_r <= ptr_r + PTR_ONE;
              // Runaway guard: the word budget is spent without seeing a terminator.
              if (wcnt_r == MAX_CNT) begin
                overrun_r <= 1'b1;
                state_r   <= NL;
              end else begin
                state_r <= RD;
              end
            end else begin
              lane_r <= lane_r + 2'd1;
            end
          end else begin
            state_r <= EMIT;
          end
        end
        NL: begin
`ifdef PRINT_NEWLINE_EN
          if (char_ready) begin
            state_r <= DONE;
          end else begin
            state_r <= NL;
          end
`else
          state_r <= DONE;
`endif
        end
        DONE:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  // Character stream driven purely from registered state, so it holds steady under backpressure.
  always_comb begin
    char_valid = 1'b0;
    char_data  = 8'h00;
    case (state_r)
      EMIT: begin
        if (cur_byte_s != 8'h00) begin
          char_valid = 1'b1;
          char_data  = cur_byte_s;
        end else begin
          char_valid = 1'b0;
        end
      end
`ifdef PRINT_NEWLINE_EN
      NL: begin
        char_valid = 1'b1;
        char_data  = 8'h0A;
      end
`endif
      default: begin
        char_valid = 1'b0;
        char_data  = 8'h00;
      end
    endcase
  end

  // Memory port mux and fetch/print status outputs.
  always_comb begin
    if (rst) begin
      mem_addr    = {WA_W{1'b0}};
      fetch_stall = 1'b0;
    end else if (state_r == IDLE) begin
      mem_addr    = fetch_addr[ADDR_W-1:2];
      fetch_stall = print_req;
    end else begin
      mem_addr    = ptr_r;
      fetch_stall = 1'b1;
    end
    print_busy    = (state_r != IDLE);
    print_done    = (state_r == DONE);
    print_overrun = overrun_r;
    fetch_valid   = fetch_valid_r;
    if (fetch_valid_r && !fetch_zero_r) begin
      fetch_instr = mem_rdata;
    end else begin
      fetch_instr = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_syscall_print_ctrl.sv
// Self-checking bench for syscall_print_ctrl: directed plan cases plus randomized
// fetches and string prints, compared against a byte-level string model.
module tb_syscall_print_ctrl;

  localparam int TB_MAX = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_stall;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic        print_req;
  logic [31:0] print_index;
  logic        print_busy;
  logic        print_done;
  logic        print_overrun;
  logic [29:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;

  int checks   = 0;
  int failures = 0;
  int ready_mode = 0;
  int last_lat = 0;

  logic [31:0] mem [int unsigned];
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic        exp_ovr;
  logic        prev_hold = 1'b0;
  logic [7:0]  prev_data = 8'h00;

  syscall_print_ctrl #(.MAX_WORDS(TB_MAX), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_stall(fetch_stall),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
    .print_req(print_req), .print_index(print_index), .print_busy(print_busy),
    .print_done(print_done), .print_overrun(print_overrun),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .char_valid(char_valid), .char_data(char_data), .char_ready(char_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input int unsigned a);
    if (mem.exists(a)) return mem[a];
    return 32'h0000_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic put_byte(input logic [31:0] addr, input logic [7:0] b);
    int unsigned wa;
    logic [31:0] w;
    wa = int'(addr >> 2);
    w  = mem_rd(wa);
    w[8*addr[1:0] +: 8] = b;
    mem[wa] = w;
  endtask

  // Reference: walk the string byte by byte from the start address with a word budget.
  task automatic model_print(input logic [31:0] idx);
    int unsigned ptr;
    int lane;
    int words;
    bit fin;
    logic [31:0] w;
    logic [7:0] b;
    exp_q.delete();
    exp_ovr = 1'b0;
    ptr = int'(idx >> 2);
    lane = int'(idx[1:0]);
    words = 0;
    fin = 0;
    while (!fin) begin
      w = mem_rd(ptr);
      words++;
      for (int l = lane; l < 4 && !fin; l++) begin
        b = w[8*l +: 8];
        if (b == 8'h00) fin = 1;
        else exp_q.push_back(b);
      end
      if (!fin) begin
        ptr = (ptr + 1) & 32'h3FFF_FFFF;
        lane = 0;
        if (words == TB_MAX) begin
          exp_ovr = 1'b1;
          fin = 1;
        end
      end
    end
`ifdef PRINT_NEWLINE_EN
    exp_q.push_back(8'h0A);
`endif
  endtask

  // Memory array with one-cycle read latency.
  always @(posedge clk) mem_rdata <= mem_rd({2'b00, mem_addr});

  // Sink ready pattern.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: char_ready = 1'b1;
      1: char_ready = ~char_ready;
      2: char_ready = 1'($urandom_range(0, 1));
      default: char_ready = 1'b0;
    endcase
  end

  // Sink: record transfers and check the byte is held while stalled.
  always @(negedge clk) begin
    if (!rst && prev_hold) begin
      check("hold_valid", {31'b0, char_valid}, 32'd1);
      check("hold_data", {24'b0, char_data}, {24'b0, prev_data});
    end
    if (!rst && char_valid && char_ready) got_q.push_back(char_data);
    prev_hold = !rst && char_valid && !char_ready;
    prev_data = char_data;
  end

  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] exp);
    @(posedge clk); #1;
    fetch_req = 1'b1;
    fetch_addr = addr;
    @(negedge clk);
    check("fetch_mem_addr", {2'b00, mem_addr}, {2'b00, addr[31:2]});
    check("fetch_stall0", {31'b0, fetch_stall}, 32'd0);
    @(posedge clk); #1;
    fetch_req = 1'b0;
    @(negedge clk);
    check("fetch_valid", {31'b0, fetch_valid}, 32'd1);
    check("fetch_instr", fetch_instr, exp);
  endtask

  task automatic run_print(input logic [31:0] idx, input int rmode, input bit with_fetch);
    int cyc;
    bit stall_ok, fv_ok;
    int n;
    model_print(idx);
    ready_mode = rmode;
    @(posedge clk); #1;
    got_q.delete();
    print_req = 1'b1;
    print_index = idx;
    if (with_fetch) begin
      fetch_req = 1'b1;
      fetch_addr = 32'h0040_0008;
    end
    @(negedge clk);
    check("strobe_stall", {31'b0, fetch_stall}, 32'd1);
    @(posedge clk); #1;
    print_req = 1'b0;
    cyc = 0;
    stall_ok = 1;
    fv_ok = 1;
    while (cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (!fetch_stall || !print_busy) stall_ok = 0;
      if (fetch_valid) fv_ok = 0;
      if (print_done) break;
    end
    last_lat = cyc;
    check("print_done", {31'b0, print_done}, 32'd1);
    check("busy_stall", {31'b0, stall_ok}, 32'd1);
    check("no_fetch_valid", {31'b0, fv_ok}, 32'd1);
    check("char_count", got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check("char", {24'b0, got_q[i]}, {24'b0, exp_q[i]});
    check("overrun", {31'b0, print_overrun}, {31'b0, exp_ovr});
    if (with_fetch) begin
      @(negedge clk);
      check("post_print_stall", {31'b0, fetch_stall}, 32'd0);
      @(posedge clk); #1;
      fetch_req = 1'b0;
      @(negedge clk);
      check("post_print_valid", {31'b0, fetch_valid}, 32'd1);
      check("post_print_instr", fetch_instr, 32'h2402_000A);
    end
  endtask

  initial begin
    int cyc;
    logic [29:0] wa;
    logic [31:0] base;
    int len;
    rst = 1'b1;
    fetch_req = 1'b0;
    fetch_addr = 32'h0;
    print_req = 1'b0;
    print_index = 32'h0;
    char_ready = 1'b1;
    mem[32'h0010_0002] = 32'h2402_000A;
    mem[32'h0010_0000] = 32'h6C6C_6548;
    mem[32'h0010_0001] = 32'h0000_006F;
    mem[32'h0000_0000] = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", {31'b0, fetch_stall}, 32'd0);
    check("rst_fvalid", {31'b0, fetch_valid}, 32'd0);
    check("rst_instr", fetch_instr, 32'd0);
    check("rst_busy", {31'b0, print_busy}, 32'd0);
    check("rst_done", {31'b0, print_done}, 32'd0);
    check("rst_overrun", {31'b0, print_overrun}, 32'd0);
    check("rst_mem_addr", {2'b00, mem_addr}, 32'd0);
    check("rst_cvalid", {31'b0, char_valid}, 32'd0);
    check("rst_cdata", {24'b0, char_data}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_fetch(32'h0040_0008, 32'h2402_000A);
    do_fetch(32'h0000_0000, 32'h0000_0000);
    for (int i = 0; i < 4; i++) begin
      wa = 30'($urandom_range(1, 32'h3FFF_FFFF));
      mem[{2'b00, wa}] = $urandom;
      do_fetch({wa, 2'($urandom_range(0, 3))}, mem[{2'b00, wa}]);
    end

    run_print(32'h0040_0000, 0, 0);
    run_print(32'h0040_0002, 1, 0);

    put_byte(32'h0050_0000, 8'h00);
    run_print(32'h0050_0000, 0, 0);
    check("empty_latency", last_lat, 32'd5);

    mem[32'h0010_0002] = 32'h2402_000A;
    run_print(32'h0040_0000, 2, 1);

    for (int i = 0; i < 4; i++) mem[32'h0020_0000 + i] = 32'h4141_4141;
    run_print(32'h0080_0000, 0, 0);
    @(negedge clk);
    check("overrun_sticky", {31'b0, print_overrun}, 32'd1);
    run_print(32'h0040_0000, 0, 0);

    for (int it = 0; it < 8; it++) begin
      base = 32'h0060_0000 + it * 64 + $urandom_range(0, 3);
      len = $urandom_range(0, 9);
      for (int k = 0; k < len; k++) put_byte(base + k, 8'($urandom_range(1, 255)));
      put_byte(base + len, 8'h00);
      run_print(base, $urandom_range(0, 2), 0);
    end

    // Reset in the middle of a stalled emission.
    ready_mode = 3;
    @(posedge clk); #1;
    print_req = 1'b1;
    print_index = 32'h0040_0000;
    @(posedge clk); #1;
    print_req = 1'b0;
    cyc = 0;
    while (cyc < 20 && !char_valid) begin
      @(negedge clk);
      cyc++;
    end
    check("pre_rst_cvalid", {31'b0, char_valid}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_cvalid", {31'b0, char_valid}, 32'd0);
    check("mid_rst_cdata", {24'b0, char_data}, 32'd0);
    check("mid_rst_busy", {31'b0, print_busy}, 32'd0);
    check("mid_rst_stall", {31'b0, fetch_stall}, 32'd0);
    repeat (2) @(posedge clk);
    got_q.delete();
    ready_mode = 0;
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("post_rst_chars", got_q.size(), 32'd0);
    check("post_rst_busy", {31'b0, print_busy}, 32'd0);
    do_fetch(32'h0040_0008, 32'h2402_000A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/syscall_print_ctrl.md
Name: syscall_print_ctrl

Overview:
- Sequencer and arbiter for the single read port of instruction memory.
- Normally passes instruction fetches straight through to the port.
- On a print-string syscall, stalls fetch and takes the port. It then walks a null-terminated string word by word from a byte address and emits its characters on a valid/ready byte stream to the console/testbench sink.
- Sits between the fetch stage, the syscall decode logic and the memory array.

Parameters:
- MAX_WORDS, 1024: maximum words read per print before forced abort (runaway-string guard).
- ADDR_W, 32: byte-address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- fetch_req  in  1  fetch requests an instruction this cycle.
- fetch_addr  in  ADDR_W  fetch byte address.
- fetch_stall  out  1  fetch not granted; hold fetch_req/fetch_addr.
- fetch_valid  out  1  fetch_instr valid (one cycle after grant).
- fetch_instr  out  32  returned instruction word.
- print_req  in  1  one-cycle start strobe for string print.
- print_index  in  ADDR_W  byte address of first character.
- print_busy  out  1  print in progress.
- print_done  out  1  one-cycle pulse at print completion.
- print_overrun  out  1  sticky until next print_req accepted; set if MAX_WORDS reached without terminator.
- mem_addr  out  ADDR_W-2  word address to memory (byte address >> 2).
- mem_rdata  in  32  memory read data, valid one cycle after mem_addr.
- char_valid  out  1  char_data valid.
- char_data  out  8  character byte.
- char_ready  in  1  sink accepts char_data.

Behaviour:
- Reset (async, rst=1): state IDLE; fetch_stall=0, fetch_valid=0, fetch_instr=0, print_busy=0, print_done=0, print_overrun=0, mem_addr=0, char_valid=0, char_data=0. Reset mid-print abandons the string; no further chars are emitted.
- States: IDLE, RD, WAIT, EMIT, NL, DONE.
- IDLE, fetch path:
  - mem_addr = fetch_addr>>2 combinationally.
  - A fetch_req is granted if print_req=0.
  - Next cycle: fetch_valid=1 and fetch_instr=mem_rdata, except fetch_instr=0 when the granted fetch_addr==0.
- IDLE + print_req=1:
  - Print wins over a simultaneous fetch_req; fetch_stall=1 that cycle.
  - Latch word pointer = print_index>>2 and start lane = print_index[1:0].
  - Clear print_overrun, reset the word counter, go to RD.
- RD: drive mem_addr = pointer, increment word counter, go to WAIT.
- WAIT: capture mem_rdata into the word buffer, set lane = start lane (first word) or 0 (later words), go to EMIT.
- EMIT, byte order within a word: lane0=[7:0], lane1=[15:8], lane2=[23:16], lane3=[31:24].
  - Current byte 0x00: terminator, go to NL; not emitted.
  - Current byte nonzero: char_valid=1, char_data=byte. char_data is held stable until char_ready=1. On transfer, advance lane.
  - After a lane3 transfer: pointer+1. If word counter == MAX_WORDS, set print_overrun and go to NL; else go to RD.
- NL: see Optional Feature; then go to DONE.
- DONE: print_done=1 for one cycle, go to IDLE.
- fetch_stall=1 and print_busy=1 in every state except IDLE. fetch_valid=0 while stalled.
- print_req outside IDLE is ignored.
- char_valid never drops without a transfer, except on reset.
- Pointer wraps modulo 2^(ADDR_W-2).
- Minimum print latency, empty string at lane 0: RD, WAIT, EMIT, NL, DONE → print_done 5 cycles after the strobe (NL is a single cycle when the newline is compiled out).

Optional Feature:
- Macro PRINT_NEWLINE_EN.
- Defined: NL emits char 0x0A with the same valid/ready handshake before DONE, including after an overrun.
- Undefined: NL is a single pass-through cycle with no emission.

Test Plan:
- Fetch passthrough: fetch_req=1, fetch_addr=0x00400008, mem word 0x00100002=0x2402000A → next cycle fetch_valid=1, fetch_instr=0x2402000A, fetch_stall=0. fetch_addr=0 → fetch_instr=0.
- Basic print: memory 0x00100000=0x6C6C6548, 0x00100001=0x0000006F; print_req with print_index=0x00400000, char_ready=1 → chars 'H','e','l','l','o' (plus 0x0A with PRINT_NEWLINE_EN), then print_done pulse; fetch_stall=1 throughout.
- Unaligned start + backpressure: same memory, print_index=0x00400002, char_ready toggling 1/0 → chars 'l','l','o'; char_data stable while char_valid=1 and char_ready=0.
- Contention: print_req and fetch_req asserted together in IDLE → print granted, fetch_stall=1 until the cycle after print_done; fetch then completes correctly.
- Overrun: MAX_WORDS=2, memory all 0x41414141 → exactly 8 'A's, print_overrun=1, print_done pulse.
- Async reset mid-EMIT with char_valid=1 → all outputs 0 immediately; after release, fetch works and no further chars appear.
